alu_trace_recorder: RTL

ALU_TRACE_RECORDER -- requirements
Module: alu_trace_recorder

---
 rtl/alu_trace_pkg.sv | 36 +++
 rtl/trace_fifo.sv | 69 ++++++
 rtl/alu_trace_recorder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_trace_pkg.sv
// rtl/alu_trace_pkg.sv - shared types, ASCII constants and helpers for the ALU trace recorder
//
// Purpose: serializer state encoding, trace character constants and the
// nibble-to-ASCII conversion used when formatting hex digits.
// Ports: none (package).

package alu_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRC1 = 3'd1,
        ST_SRC2 = 3'd2,
        ST_CTRL = 3'd3,
        ST_RES  = 3'd4,
        ST_SEP  = 3'd5,
        ST_NL   = 3'd6
    } trace_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NL    = 8'h0a;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h61;

    localparam int CTRL_WIDTH  = 12;
    localparam int CTRL_DIGITS = CTRL_WIDTH / 4;

    // Lowercase hex digit for a 4-bit value.
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end else begin
            return ASCII_A + {4'h0, nib} - 8'd10;
        end
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO for the ALU trace recorder
//
// Purpose: stores captured ALU records until the serializer consumes them.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata       write request and record; a push while full is taken
//                     only if a pop happens in the same cycle
//   pop, rdata        read request and head record (rdata valid while !empty)
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH

module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being read out this cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_trace_recorder.sv
// rtl/alu_trace_recorder.sv - captures ALU transactions and streams them as ASCII hex lines
//
// Purpose: each accepted capture is queued and later emitted as
// "src1 src2 control result\n" in lowercase, zero-padded hex.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cap_valid, cap_ready       capture handshake for one ALU transaction
//   alu_src1, alu_src2         operands (DATA_WIDTH)
//   alu_control                12-bit one-hot opcode
//   alu_result                 result (DATA_WIDTH)
//   out_valid, out_data        trace byte stream
//   out_ready                  sink accepts out_data
//   drop_count                 saturating count of refused captures

module alu_trace_recorder
    import alu_trace_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cap_valid,
    output logic                  cap_ready,
    input  logic [DATA_WIDTH-1:0] alu_src1,
    input  logic [DATA_WIDTH-1:0] alu_src2,
    input  logic [11:0]           alu_control,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic [7:0]            drop_count
);

    localparam int NIB   = DATA_WIDTH / 4;
    localparam int REC_W = 3 * DATA_WIDTH + CTRL_WIDTH;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [AW:0] FULL_CNT        = (AW + 1)'(DEPTH);
    localparam logic [7:0]  LAST_DATA_DIGIT = 8'(NIB - 1);
    localparam logic [7:0]  LAST_CTRL_DIGIT = 8'(CTRL_DIGITS - 1);

    logic [REC_W-1:0] fifo_wdata;
    logic [REC_W-1:0] fifo_rdata;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;

    trace_state_t     state;
    trace_state_t     sep_next;
    trace_state_t     field_next;
    logic [7:0]       digit;
    logic             field_done;
    logic [REC_W-1:0] rec;

    logic [DATA_WIDTH-1:0] rec_src1;
    logic [DATA_WIDTH-1:0] rec_src2;
    logic [CTRL_WIDTH-1:0] rec_ctrl;
    logic [DATA_WIDTH-1:0] rec_res;
    logic [DATA_WIDTH-1:0] data_field;
    logic [3:0]            data_nib;
    logic [3:0]            ctrl_nib;

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
    // Occupancy-based so a pop in the same cycle never opens the door early.
    assign cap_ready  = !reset && (fifo_count < FULL_CNT);
    assign fifo_push  = cap_valid && cap_ready && !fifo_full;
    assign fifo_wdata = {alu_src1, alu_src2, alu_control, alu_result};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (cap_valid && !cap_ready && (drop_count != 8'hff)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    assign rec_src1 = rec[REC_W-1 -: DATA_WIDTH];
    assign rec_src2 = rec[2*DATA_WIDTH+CTRL_WIDTH-1 -: DATA_WIDTH];
    assign rec_ctrl = rec[DATA_WIDTH+CTRL_WIDTH-1 -: CTRL_WIDTH];
    assign rec_res  = rec[DATA_WIDTH-1:0];

    assign out_valid = (state != ST_IDLE);

    // Loading from IDLE, or straight out of the newline so lines abut.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_NL) && out_ready));

    always_comb begin
        field_done = (state == ST_CTRL) ? (digit == LAST_CTRL_DIGIT)
                                        : (digit == LAST_DATA_DIGIT);
        case (state)
            ST_SRC1: field_next = ST_SRC2;
            ST_SRC2: field_next = ST_CTRL;
            ST_CTRL: field_next = ST_RES;
            default: field_next = ST_SRC2;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sep_next <= ST_SRC2;
            digit    <= 8'd0;
            rec      <= '0;
        end else if (fifo_pop) begin
            rec   <= fifo_rdata;
            state <= ST_SRC1;
            digit <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_SRC1, ST_SRC2, ST_CTRL, ST_RES: begin
                    if (out_ready) begin
                        if (field_done) begin
                            digit    <= 8'd0;
                            state    <= (state == ST_RES) ? ST_NL : ST_SEP;
                            sep_next <= field_next;
                        end else begin
                            digit <= digit + 8'd1;
                        end
                    end
                end
                ST_SEP: begin
                    if (out_ready) begin
                        state <= sep_next;
                    end
                end
                ST_NL: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte presented is a pure function of state/digit/record, so it holds
    // steady for as long as the sink stalls.
    always_comb begin
        case (state)
            ST_SRC1: data_field = rec_src1;
            ST_SRC2: data_field = rec_src2;
            default: data_field = rec_res;
        endcase
        data_nib = 4'(data_field >> (4 * (NIB - 1 - int'(digit))));
        ctrl_nib = 4'(rec_ctrl >> (4 * (CTRL_DIGITS - 1 - int'(digit))));
        case (state)
            ST_SRC1, ST_SRC2, ST_RES: out_data = nib_to_ascii(data_nib);
            ST_CTRL:                  out_data = nib_to_ascii(ctrl_nib);
            ST_SEP:                   out_data = ASCII_SPACE;
            ST_NL:                    out_data = ASCII_NL;
            default:                  out_data = 8'h00;
        endcase
    end

endmodule
